// File: rtl/count_timer_ctrl.sv
// rtl/count_timer_ctrl.sv - run/pause/clear sequencer for the two-digit BCD count shown on the digit decoders
// Optional build macro DONE_FLASH_EN: flash the display blank request while in DONE.
module count_timer_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  input  logic [3:0] preset_ones,
  input  logic [3:0] preset_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       blank
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [3:0]    ones_n, tens_n;
  logic [3:0]    step_ones, step_tens;
  logic [3:0]    clamp_ones, clamp_tens;
  logic          dir_q, dir_q_n;
  logic          tick_c;

  function automatic logic is_term(input logic d, input logic [3:0] t, input logic [3:0] o);
    is_term = d ? (t == 4'd0 && o == 4'd0) : (t == 4'd9 && o == 4'd9);
  endfunction

  assign clamp_ones = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
  assign clamp_tens = (preset_tens > 4'd9) ? 4'd9 : preset_tens;

  // One BCD step in the latched direction; carry/borrow across the digit pair.
  always_comb begin
    step_ones = ones;
    step_tens = tens;
    if (!dir_q) begin
      if (ones == 4'd9) begin
        step_ones = 4'd0;
        step_tens = tens + 4'd1;
      end else begin
        step_ones = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        step_ones = 4'd9;
        step_tens = tens - 4'd1;
      end else begin
        step_ones = ones - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    ones_n  = ones;
    tens_n  = tens;
    dir_q_n = dir_q;
    tick_c  = 1'b0;
    if (clear) begin
      dir_q_n = dir;
      ones_n  = dir ? clamp_ones : 4'd0;
      tens_n  = dir ? clamp_tens : 4'd0;
      pre_n   = '0;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_stop) begin
            dir_q_n = dir;
            if (is_term(dir, tens, ones)) begin
              state_n = S_DONE;
            end else begin
              state_n = S_RUN;
              pre_n   = '0;
            end
          end
        end
        S_RUN: begin
          // A pause request on the wrap cycle wins: no step, prescaler holds.
          if (start_stop) begin
            state_n = S_PAUSE;
          end else if (pre == PRE_MAX) begin
            pre_n  = '0;
            tick_c = 1'b1;
            if (!is_term(dir_q, tens, ones)) begin
              ones_n = step_ones;
              tens_n = step_tens;
            end
            if (is_term(dir_q, step_tens, step_ones) || is_term(dir_q, tens, ones)) begin
              state_n = S_DONE;
            end
          end else begin
            pre_n = pre + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start_stop) state_n = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pre     <= '0;
      ones    <= 4'd0;
      tens    <= 4'd0;
      dir_q   <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      ones    <= ones_n;
      tens    <= tens_n;
      dir_q   <= dir_q_n;
      running <= (state_n == S_RUN);
      done    <= (state_n == S_DONE);
    end
  end

  assign tick = tick_c;

`ifdef DONE_FLASH_EN
  localparam int HALF = (TICK_DIV / 2 < 1) ? 1 : TICK_DIV / 2;
  localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [FW-1:0] flash_cnt;
  logic          blank_q;

  // Leaving DONE (including via clear) drops blank and rearms the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (state_n != S_DONE) begin
      flash_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (state != S_DONE) begin
      flash_cnt <= '0;
      blank_q   <= 1'b1;
    end else if (flash_cnt == FW'(HALF - 1)) begin
      flash_cnt <= '0;
      blank_q   <= ~blank_q;
    end else begin
      flash_cnt <= flash_cnt + FW'(1);
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_count_timer_ctrl.sv
// tb/tb_count_timer_ctrl.sv - randomized and directed check of count_timer_ctrl against an integer-valued model
module tb_count_timer_ctrl;

  localparam int TD   = 4;
  localparam int HALF = (TD / 2 < 1) ? 1 : TD / 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] preset_ones = 4'd0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] ones, tens;
  logic       running, done, tick, blank;

  count_timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .dir(dir),
    .preset_ones(preset_ones), .preset_tens(preset_tens),
    .ones(ones), .tens(tens), .running(running), .done(done),
    .tick(tick), .blank(blank)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: count value as a plain integer 0..99, phase = cycles since last step.
  int mode = M_IDLE;
  int val = 0;
  int phase = 0;
  int done_age = 0;
  bit dq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t val=%0d)", tag, got, exp, $time, val);
    end
  endtask

  function automatic bit at_term(input int v, input bit d);
    return d ? (v == 0) : (v == 99);
  endfunction

  function automatic int clampd(input logic [3:0] p);
    return (p > 4'd9) ? 9 : int'(p);
  endfunction

  function automatic bit exp_blank();
`ifdef DONE_FLASH_EN
    return (mode == M_DONE) && ((done_age / HALF) % 2 == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit ss, input bit clr);
    int prev = mode;
    if (clr) begin
      dq    = dir;
      val   = dir ? clampd(preset_tens) * 10 + clampd(preset_ones) : 0;
      phase = 0;
      mode  = M_IDLE;
    end else if (mode == M_IDLE) begin
      if (ss) begin
        dq = dir;
        if (at_term(val, dq)) mode = M_DONE;
        else begin
          mode  = M_RUN;
          phase = 0;
        end
      end
    end else if (mode == M_RUN) begin
      if (ss) mode = M_PAUSE;
      else if (phase == TD - 1) begin
        phase = 0;
        val   = dq ? val - 1 : val + 1;
        if (at_term(val, dq)) mode = M_DONE;
      end else phase++;
    end else if (mode == M_PAUSE) begin
      if (ss) mode = M_RUN;
    end
    if (mode == M_DONE) done_age = (prev == M_DONE) ? done_age + 1 : 0;
  endtask

  task automatic check_outputs();
    check("ones", ones, val % 10);
    check("tens", tens, val / 10);
    check("running", running, mode == M_RUN);
    check("done", done, mode == M_DONE);
    check("blank", blank, exp_blank());
  endtask

  task automatic cyc(input bit ss, input bit clr);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    #1;
    check("tick", tick, (mode == M_RUN) && !clr && !ss && (phase == TD - 1));
    @(posedge clk);
    #1;
    model_edge(ss, clr);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic run_until_val(input int target, input int limit);
    int n = 0;
    while (val != target && n < limit) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    check("reach_bound", n < limit, 1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    #2 rst = 1'b0;
    #1;
    mode = M_IDLE; val = 0; phase = 0; dq = 0; done_age = 0;
    check("rst_tick", tick, 0);
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1;
    check("reset_ones", ones, 0);
    check("reset_tens", tens, 0);
    check("reset_running", running, 0);
    check("reset_done", done, 0);
    check("reset_tick", tick, 0);
    check("reset_blank", blank, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Up count through carries to 99.
    dir = 1'b0;
    cyc(0, 1);
    cyc(1, 0);
    run_until_val(99, 500);
    check("up_done99", done, 1);
    check("up_running99", running, 0);
    idle_cycles(6);
    cyc(1, 0);

    // Down count from 12 with borrow.
    dir = 1'b1; preset_tens = 4'd1; preset_ones = 4'd2;
    cyc(0, 1);
    cyc(1, 0);
    run_until_val(0, 100);
    check("down_done00", done, 1);
    idle_cycles(3);

    // Pause with the prescaler held at 2, then resume.
    dir = 1'b0;
    cyc(0, 1);
    cyc(1, 0);
    run_until_val(3, 40);
    begin
      int n = 0;
      while (phase != 2 && n < 10) begin cyc(0, 0); n++; end
      check("phase_bound", n < 10, 1);
    end
    cyc(1, 0);
    idle_cycles(10);
    cyc(1, 0);
    idle_cycles(8);

    // Clear and start_stop together while running at 37.
    run_until_val(37, 200);
    cyc(1, 1);
    check("clr_ss_running", running, 0);
    idle_cycles(5);

    // Terminal start and preset clamp.
    dir = 1'b1; preset_tens = 4'd0; preset_ones = 4'd0;
    cyc(0, 1);
    cyc(1, 0);
    check("term_done", done, 1);
    idle_cycles(7);
    preset_tens = 4'hF; preset_ones = 4'hF;
    cyc(0, 1);
    check("clamp_ones", ones, 9);
    check("clamp_tens", tens, 9);

    // Reset mid-run at 55.
    dir = 1'b0;
    cyc(0, 1);
    cyc(1, 0);
    run_until_val(55, 300);
    async_reset();
    idle_cycles(3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 40) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) begin
        preset_ones = 4'($urandom_range(0, 15));
        preset_tens = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1500) == 0) async_reset();
      else cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
